// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the sr_latch upstream controller.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SET_PULSE,
        RST_PULSE,
        GAP
    } sr_state_t;

    localparam int GAP_CYCLES = 1;

endpackage

// File: rtl/sr_debounce.sv
// One button path: 2-flop synchroniser, counter debounce, registered rising-edge request.
module sr_debounce
    import sr_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic req
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic             vld_p0;
    logic             vld_p1;
    logic             level;
    logic             level_q;
    logic             armed;
    logic [CNT_W-1:0] cnt;

    // A button already held across reset must be seen released before it can request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            armed   <= 1'b0;
            cnt     <= '0;
            req     <= 1'b0;
        end else begin
            sync_p0 <= btn_i;
            sync_p1 <= sync_p0;
            vld_p0  <= 1'b1;
            vld_p1  <= vld_p0;
            if (vld_p1 && !sync_p1) begin
                armed <= 1'b1;
            end
            if (sync_p1 != level) begin
                if (cnt == CNT_LAST) begin
                    level <= sync_p1;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
            level_q <= level;
            req     <= level & ~level_q & armed;
        end
    end

endmodule

// File: rtl/sr_ctrl_debounce.sv
// Debounced S/R pulse sequencer for sr_latch; S and R are never high together.
// Optional macro SR_PRIORITY_RESET_EN: on simultaneous requests reset wins instead of both dropping.
module sr_ctrl_debounce
    import sr_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES    = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn_i,
    input  logic rst_btn_i,
    output logic S,
    output logic R,
    output logic busy,
    output logic conflict
);

    localparam int PCNT_W = $clog2(PULSE_CYCLES + GAP_CYCLES + 1);
    localparam logic [PCNT_W-1:0] PULSE_LAST = PCNT_W'(PULSE_CYCLES - 1);
    localparam logic [PCNT_W-1:0] GAP_LAST   = PCNT_W'(GAP_CYCLES - 1);

    sr_state_t         state;
    logic [PCNT_W-1:0] pcnt;
    logic              set_req;
    logic              rst_req;
    logic              set_pend;
    logic              rst_pend;
    logic              set_want;
    logic              rst_want;

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_i (set_btn_i),
        .req   (set_req)
    );

    sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn_i (rst_btn_i),
        .req   (rst_req)
    );

    assign set_want = set_req | set_pend;
    assign rst_want = rst_req | rst_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pcnt     <= '0;
            set_pend <= 1'b0;
            rst_pend <= 1'b0;
            S        <= 1'b0;
            R        <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            conflict <= 1'b0;
            // Requests seen while busy collapse into one pending bit per direction.
            if (state != IDLE) begin
                if (set_req) set_pend <= 1'b1;
                if (rst_req) rst_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (set_want && rst_want) begin
                        conflict <= 1'b1;
                        set_pend <= 1'b0;
                        rst_pend <= 1'b0;
`ifdef SR_PRIORITY_RESET_EN
                        state    <= RST_PULSE;
                        R        <= 1'b1;
                        busy     <= 1'b1;
                        pcnt     <= '0;
`endif
                    end else if (set_want) begin
                        set_pend <= 1'b0;
                        state    <= SET_PULSE;
                        S        <= 1'b1;
                        busy     <= 1'b1;
                        pcnt     <= '0;
                    end else if (rst_want) begin
                        rst_pend <= 1'b0;
                        state    <= RST_PULSE;
                        R        <= 1'b1;
                        busy     <= 1'b1;
                        pcnt     <= '0;
                    end
                end
                SET_PULSE: begin
                    if (pcnt == PULSE_LAST) begin
                        state <= GAP;
                        S     <= 1'b0;
                        pcnt  <= '0;
                    end else begin
                        pcnt <= pcnt + PCNT_W'(1);
                    end
                end
                RST_PULSE: begin
                    if (pcnt == PULSE_LAST) begin
                        state <= GAP;
                        R     <= 1'b0;
                        pcnt  <= '0;
                    end else begin
                        pcnt <= pcnt + PCNT_W'(1);
                    end
                end
                GAP: begin
                    if (pcnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        pcnt  <= '0;
                    end else begin
                        pcnt <= pcnt + PCNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    S     <= 1'b0;
                    R     <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_ctrl_debounce.sv
// Directed and random bench for sr_ctrl_debounce (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2).
module tb_sr_ctrl_debounce;

    logic clk;
    logic rst_n;
    logic set_btn_i;
    logic rst_btn_i;
    logic S;
    logic R;
    logic busy;
    logic conflict;

    int checks;
    int failures;

    sr_ctrl_debounce #(.DEBOUNCE_CYCLES(4), .PULSE_CYCLES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_btn_i (set_btn_i),
        .rst_btn_i (rst_btn_i),
        .S         (S),
        .R         (R),
        .busy      (busy),
        .conflict  (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int s_run;
    int r_run;

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        set_btn_i = 1'b0;
        rst_btn_i = 1'b0;
        idle(3);
        check("rst_S", S, 0);
        check("rst_R", R, 0);
        check("rst_busy", busy, 0);
        check("rst_conflict", conflict, 0);
        rst_n = 1'b1;
        idle(10);

        // Clean set press: input first sampled at edge i=0, S on edges 7-8, gap on 9.
        set_btn_i = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            step();
            check("t1_S", S, (i == 7 || i == 8));
            check("t1_busy", busy, (i >= 7 && i <= 9));
            check("t1_R", R, 0);
        end
        set_btn_i = 1'b0;
        idle(20);

        // Bounce shorter than the debounce window.
        for (int i = 0; i < 24; i++) begin
            set_btn_i = (i < 4) ? ~i[0] : 1'b0;
            step();
            check("bounce_S", S, 0);
            check("bounce_conflict", conflict, 0);
        end
        idle(10);

        // Simultaneous presses.
        set_btn_i = 1'b1;
        rst_btn_i = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            step();
            check("conf_pulse", conflict, (i == 7));
            check("conf_S", S, 0);
`ifdef SR_PRIORITY_RESET_EN
            check("conf_R", R, (i == 7 || i == 8));
            check("conf_busy", busy, (i >= 7 && i <= 9));
`else
            check("conf_R", R, 0);
            check("conf_busy", busy, 0);
`endif
        end
        set_btn_i = 1'b0;
        rst_btn_i = 1'b0;
        idle(20);

        // Reset request arriving during a set pulse is held pending.
        set_btn_i = 1'b1;
        for (int i = 0; i <= 15; i++) begin
            step();
            if (i == 0) rst_btn_i = 1'b1;
            check("pend_S", S, (i == 7 || i == 8));
            check("pend_R", R, (i == 11 || i == 12));
            check("pend_busy", busy, ((i >= 7 && i <= 9) || (i >= 11 && i <= 13)));
            check("pend_excl", S & R, 0);
        end
        set_btn_i = 1'b0;
        rst_btn_i = 1'b0;
        idle(20);

        // Asynchronous reset in the middle of an S pulse.
        set_btn_i = 1'b1;
        for (int i = 0; i <= 7; i++) step();
        check("ar_S_before", S, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_S_async", S, 0);
        check("ar_busy_async", busy, 0);
        check("ar_R_async", R, 0);
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("ar_held_S", S, 0);
            check("ar_held_busy", busy, 0);
        end
        set_btn_i = 1'b0;
        idle(10);
        set_btn_i = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            step();
            check("ar_repress_S", S, (i == 7 || i == 8));
        end
        set_btn_i = 1'b0;
        idle(20);

        // Random slow-toggling buttons.
        s_run = 0;
        r_run = 0;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(15) == 0) set_btn_i = ~set_btn_i;
            if ($urandom_range(15) == 0) rst_btn_i = ~rst_btn_i;
            step();
            check("rand_excl", S & R, 0);
            if (S) s_run++;
            else if (s_run != 0) begin
                check("rand_S_width", s_run, 2);
                s_run = 0;
            end
            if (R) r_run++;
            else if (r_run != 0) begin
                check("rand_R_width", r_run, 2);
                r_run = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
